div_iter_unit: RTL and testbench
================================

Name: div_iter_unit

Overview:
- Multi-cycle radix-2 restoring integer divider. It is the responder side of the EX-stage divide handshake.
- The ALU raises a request with operands and a signedness flag, holds them stable while this block asserts stall, and samples a 64-bit {remainder, quotient} result in the cycle stall drops.
- The result feeds the HI/LO register: HI = remainder, LO = quotient.

Parameters:
- WIDTH, 32, operand width. Result is 2*WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  EX-stage flush. Synchronous. Cancels any operation in progress.
- dividend  in  WIDTH  numerator (rs). Must stay stable while stall=1.
- divisor  in  WIDTH  denominator (rt). Must stay stable while stall=1.
- valid  in  1  divide request. Held high by the initiator while stall=1.
- div_signed  in  1  1 = two's-complement (DIV), 0 = unsigned (DIVU).
- stall  out  1  pipeline hold request.
- result  out  2*WIDTH  registered result: {remainder, quotient}.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, result=0, all internal regs=0. stall is then 0. Reset mid-operation abandons the operation.
- stall is combinational: stall = valid & ~flush & (state != DONE).
- States:
  - IDLE, valid=1, flush=0, divisor!=0: latch |dividend|, |divisor|, quotient sign (signs differ & div_signed), remainder sign (dividend[WIDTH-1] & div_signed). Clear the partial remainder and the iteration counter. Go to RUN.
  - IDLE, valid=1, flush=0, divisor==0: load result={dividend, all-ones}. Go to DONE.
  - RUN: one iteration per cycle. Shift {rem, quo} left by 1, trial-subtract the divisor, keep the difference and set the quotient LSB if the difference is non-negative. The counter runs 0..WIDTH-1.
  - RUN, on iteration WIDTH-1: apply sign correction. Negate the quotient if its sign flag is set; negate the remainder if its sign flag is set. Register into result. Go to DONE.
  - DONE: stall=0 for exactly one cycle and result is valid. Unconditionally go to IDLE. A request still present in DONE is not restarted.
- Latency, normal divide: request seen in IDLE at cycle 0. stall=1 for cycles 0..WIDTH (33 cycles at WIDTH=32). stall=0 and result valid at cycle WIDTH+1.
- Latency, divide by zero: stall=1 at cycle 0, stall=0 at cycle 1.
- Back-to-back requests: the next request is accepted in the IDLE cycle that follows DONE.
- flush=1 in any state: stall=0 in that cycle, next state=IDLE, result unchanged. flush has priority over valid.
- valid dropped (without flush) in RUN: abort and return to IDLE. result is unchanged.
- Signed arithmetic: the quotient truncates toward zero; the remainder takes the sign of the dividend.
- Signed overflow: MIN_INT / -1 gives quotient=MIN_INT and remainder=0 (natural wrap). No exception is raised.
- Unsigned mode: operands are used raw; no sign flags are set.
- result holds its value between operations. It is written only on a RUN completion or a divide-by-zero load.
- The partial remainder uses WIDTH+1 bits so the trial subtraction never loses the borrow.

Decomposition:
- defines.vh (shared include): state encodings DIV_IDLE, DIV_RUN, DIV_DONE (2-bit) and the all-ones divide-by-zero quotient constant.
- Single module; no sub-module is needed. The absolute-value and negate logic is inline.

Test Plan:
- Unsigned 100/7, div_signed=0 → stall high 33 cycles, then result=0x00000002_0000000E with stall=0 for one cycle, then IDLE.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) → result=0xFFFFFFFF_FFFFFFFD (r=-1, q=-3). Also 7/-2 → 0x00000001_FFFFFFFD.
- Signed 0x80000000 / 0xFFFFFFFF → result=0x00000000_80000000. Unsigned 0xFFFFFFFF / 0x00000001 → 0x00000000_FFFFFFFF.
- Divide by zero, 5/0 → stall high 1 cycle, then result=0x00000005_FFFFFFFF.
- Start 100/7, assert flush in RUN cycle 10 → stall=0 that cycle, result keeps its prior value. A following request for 9/3 completes normally to 0x00000000_00000003.
- Back-to-back 100/7 then 50/5 with valid held → second stall rises at cycle 34 and the second result is 0x00000000_0000000A. Separately, rst=0 mid-RUN → stall=0 and result=0 immediately.

Source files
------------

// File: rtl/div_iter_unit_pkg.sv
// Shared types and constants for the iterative restoring divider.
// The state encoding is also exported on the divider's debug port.
package div_iter_unit_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Stall is requested for the whole operation except the single result cycle.
  function automatic logic div_state_busy(input div_state_e st);
    return st != DIV_DONE;
  endfunction

endpackage

// File: rtl/div_iter_unit.sv
// Multi-cycle radix-2 restoring divider answering the EX-stage divide handshake.
// Produces {remainder, quotient} for the HI/LO register pair.
module div_iter_unit
  import div_iter_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               valid,
  input  logic               div_signed,
  output logic               stall,
  output logic [2*WIDTH-1:0] result,
  output div_state_e         dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  div_state_e         state_q, state_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               dvd_neg, dvs_neg;
  logic [WIDTH-1:0]   abs_dividend, abs_divisor;
  logic [WIDTH:0]     rem_shift, trial, rem_iter;
  logic [WIDTH-1:0]   quo_iter, quo_fin, rem_fin;

  // Handshake: the initiator holds valid and operands steady while stall=1;
  // stall falls for exactly the one cycle in which result is sampled.
  // Reset also forces stall low so a held request does not freeze the pipe.
  assign stall     = rst & valid & ~flush & div_state_busy(state_q);
  assign result    = result_q;
  assign dbg_state = state_q;

  always_comb begin
    dvd_neg      = div_signed & dividend[WIDTH-1];
    dvs_neg      = div_signed & divisor[WIDTH-1];
    abs_dividend = dvd_neg ? -dividend : dividend;
    abs_divisor  = dvs_neg ? -divisor : divisor;

    // One restoring step; the extra remainder bit keeps the borrow visible.
    rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvs_q};
    rem_iter  = trial[WIDTH] ? rem_shift : trial;
    quo_iter  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

    quo_fin = qneg_q ? -quo_iter : quo_iter;
    rem_fin = rneg_q ? -rem_iter[WIDTH-1:0] : rem_iter[WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    if (flush) begin
      state_d = DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (valid) begin
            if (divisor == '0) begin
              result_d = {dividend, {WIDTH{1'b1}}};
              state_d  = DIV_DONE;
            end else begin
              quo_d   = abs_dividend;
              dvs_d   = abs_divisor;
              rem_d   = '0;
              cnt_d   = '0;
              qneg_d  = dvd_neg ^ dvs_neg;
              rneg_d  = dvd_neg;
              state_d = DIV_RUN;
            end
          end
        end
        DIV_RUN: begin
          if (!valid) begin
            state_d = DIV_IDLE;
          end else begin
            rem_d = rem_iter;
            quo_d = quo_iter;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_ITER) begin
              result_d = {rem_fin, quo_fin};
              state_d  = DIV_DONE;
            end
          end
        end
        DIV_DONE: state_d = DIV_IDLE;
        default:  state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DIV_IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed and randomized checks of div_iter_unit against an arithmetic model.
module tb_div_iter_unit;
  import div_iter_unit_pkg::*;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic           valid;
  logic           div_signed;
  logic [W-1:0]   dividend;
  logic [W-1:0]   divisor;
  logic           stall;
  logic [2*W-1:0] result;
  div_state_e     dbg_state;

  int             n_checks = 0;
  int             n_pass   = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_res;

  div_iter_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .dividend   (dividend),
    .divisor    (divisor),
    .valid      (valid),
    .div_signed (div_signed),
    .stall      (stall),
    .result     (result),
    .dbg_state  (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference: magnitude divide, then apply the sign rules.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    logic          an, bn;
    logic [W-1:0]  ua, ub, q, r;
    if (b == '0) return {a, {W{1'b1}}};
    an = s && a[W-1];
    bn = s && b[W-1];
    ua = an ? -a : a;
    ub = bn ? -b : b;
    q  = ua / ub;
    r  = ua % ub;
    if (an != bn) q = -q;
    if (an) r = -r;
    return {r, q};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Driver: issue one request and follow it to the result cycle.
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input int exp_lat, input logic hold,
                         input logic [2*W-1:0] exp);
    int cycles;
    @(posedge clk); #1;
    dividend   = a;
    divisor    = b;
    div_signed = s;
    valid      = 1'b1;
    exp_q.push_back(exp);
    cycles = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      cycles++;
      if (cycles > 200) break;
    end
    check({tag, " latency"}, 64'(cycles), 64'(exp_lat));
    check({tag, " result"}, result, exp_q.pop_front());
    last_res = exp;
    if (!hold) begin
      @(posedge clk); #1;
      valid = 1'b0;
    end
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic         s;
    logic [2*W-1:0] e;

    // Reset with a request already pending
    rst = 1'b0; flush = 1'b0; valid = 1'b1; div_signed = 1'b0;
    dividend = 32'd100; divisor = 32'd7;
    repeat (3) @(posedge clk);
    #1;
    check("reset stall", 64'(stall), 64'd0);
    check("reset result", result, 64'd0);
    check("reset state", 64'(dbg_state), 64'(DIV_IDLE));
    valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    last_res = '0;

    // Directed cases
    run_div("u100/7", 32'd100, 32'd7, 1'b0, 33, 1'b0, 64'h00000002_0000000E);
    check("idle after done", 64'(dbg_state), 64'(DIV_IDLE));
    run_div("s-7/2", 32'hFFFFFFF9, 32'd2, 1'b1, 33, 1'b0, 64'hFFFFFFFF_FFFFFFFD);
    run_div("s7/-2", 32'd7, 32'hFFFFFFFE, 1'b1, 33, 1'b0, 64'h00000001_FFFFFFFD);
    run_div("smin/-1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 33, 1'b0, 64'h00000000_80000000);
    run_div("umax/1", 32'hFFFFFFFF, 32'd1, 1'b0, 33, 1'b0, 64'h00000000_FFFFFFFF);
    run_div("div0", 32'd5, 32'd0, 1'b1, 1, 1'b0, 64'h00000005_FFFFFFFF);

    // Flush in RUN cycle 10
    @(posedge clk); #1;
    dividend = 32'd100; divisor = 32'd7; div_signed = 1'b0; valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("pre-flush state", 64'(dbg_state), 64'(DIV_RUN));
    flush = 1'b1;
    @(negedge clk);
    check("flush stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; valid = 1'b0;
    check("flush state", 64'(dbg_state), 64'(DIV_IDLE));
    check("flush result kept", result, last_res);
    run_div("u9/3", 32'd9, 32'd3, 1'b0, 33, 1'b0, 64'h00000000_00000003);

    // Valid dropped mid-RUN
    @(posedge clk); #1;
    dividend = 32'd1000; divisor = 32'd3; valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    valid = 1'b0;
    @(posedge clk); #1;
    check("abort state", 64'(dbg_state), 64'(DIV_IDLE));
    check("abort result kept", result, last_res);

    // Back-to-back with valid held through DONE
    run_div("b2b first", 32'd100, 32'd7, 1'b0, 33, 1'b1, 64'h00000002_0000000E);
    run_div("b2b second", 32'd50, 32'd5, 1'b0, 33, 1'b0, 64'h00000000_0000000A);

    // Randomized operands
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = 32'($urandom_range(1, 20));
        3:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      e = model(a, b, s);
      run_div($sformatf("rand%0d", i), a, b, s, (b == '0) ? 1 : 33, 1'b0, e);
    end

    // Asynchronous reset mid-RUN
    @(posedge clk); #1;
    dividend = 32'd100; divisor = 32'd7; div_signed = 1'b0; valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrun reset stall", 64'(stall), 64'd0);
    check("midrun reset result", result, 64'd0);
    check("midrun reset state", 64'(dbg_state), 64'(DIV_IDLE));
    valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    last_res = '0;
    run_div("post-reset u9/3", 32'd9, 32'd3, 1'b0, 33, 1'b0, 64'h00000000_00000003);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
